// File: rtl/io_bus_arb.sv
// Two-master arbiter (68K side and Z80 bank window) for a shared I/O register block.
// Round-robin on ties, DTACK handshake passthrough, and a timeout abort that reports BUS_ERR.
module io_bus_arb #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CE,
    input  logic       M_SEL,
    input  logic       M_RNW,
    input  logic [4:1] M_A,
    input  logic [7:0] M_DI,
    output logic [7:0] M_DO,
    output logic       M_DTACK_N,
    input  logic       Z_SEL,
    input  logic       Z_RNW,
    input  logic [4:1] Z_A,
    input  logic [7:0] Z_DI,
    output logic [7:0] Z_DO,
    output logic       Z_DTACK_N,
    output logic       IO_SEL,
    output logic       IO_RNW,
    output logic [4:1] IO_A,
    output logic [7:0] IO_DI,
    input  logic [7:0] IO_DO,
    input  logic       IO_DTACK_N,
    output logic       BUS_ERR
);
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]    state, state_nx;
    logic          owner, owner_nx;   // 1 = Z80 side
    logic          last, last_nx;     // 1 = Z80 side granted last
    logic [7:0]    cnt, cnt_nx;
    logic [7:0]    cnt_inc;
    logic          owner_sel;
    logic          pick_z;
    logic          io_sel_nx, io_rnw_nx, bus_err_nx;
    logic [AW-1:0] io_a_nx;
    logic [DW-1:0] io_di_nx;
    logic [DW-1:0] m_do_nx, z_do_nx;
    logic          m_ack_nx, z_ack_nx;

    // Next-state and next-output logic
    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        last_nx    = last;
        cnt_nx     = cnt;
        io_sel_nx  = IO_SEL;
        io_rnw_nx  = IO_RNW;
        io_a_nx    = IO_A;
        io_di_nx   = IO_DI;
        m_do_nx    = M_DO;
        z_do_nx    = Z_DO;
        m_ack_nx   = M_DTACK_N;
        z_ack_nx   = Z_DTACK_N;
        bus_err_nx = 1'b0;
        owner_sel  = owner ? Z_SEL : M_SEL;
        cnt_inc    = cnt + 8'd1;
        pick_z     = Z_SEL && (!M_SEL || !last);

        case (state)
            S_IDLE: begin
                if (M_SEL || Z_SEL) begin
                    owner_nx  = pick_z;
                    last_nx   = pick_z;
                    io_a_nx   = pick_z ? Z_A : M_A;
                    io_rnw_nx = pick_z ? Z_RNW : M_RNW;
                    io_di_nx  = pick_z ? Z_DI : M_DI;
                    io_sel_nx = 1'b1;
                    cnt_nx    = 8'd0;
                    state_nx  = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!owner_sel) begin
                    io_sel_nx = 1'b0;
                    state_nx  = S_RELEASE;
                end else if (!IO_DTACK_N) begin
                    if (owner) begin
                        z_ack_nx = 1'b0;
                        if (IO_RNW) z_do_nx = IO_DO;
                    end else begin
                        m_ack_nx = 1'b0;
                        if (IO_RNW) m_do_nx = IO_DO;
                    end
                    state_nx = S_HOLD;
                end else if (cnt_inc == TIMEOUT) begin
                    // Abort once TIMEOUT cycles have been spent in GRANT
                    cnt_nx     = cnt_inc;
                    io_sel_nx  = 1'b0;
                    bus_err_nx = 1'b1;
                    if (owner) begin
                        z_ack_nx = 1'b0;
                        z_do_nx  = 8'hFF;
                    end else begin
                        m_ack_nx = 1'b0;
                        m_do_nx  = 8'hFF;
                    end
                    state_nx = S_HOLD;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            S_HOLD: begin
                if (!owner_sel) begin
                    m_ack_nx  = 1'b1;
                    z_ack_nx  = 1'b1;
                    io_sel_nx = 1'b0;
                    state_nx  = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (IO_DTACK_N) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State and output registers; reset is independent of CE
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            cnt       <= 8'd0;
            IO_SEL    <= 1'b0;
            IO_RNW    <= 1'b1;
            IO_A      <= AW'(0);
            IO_DI     <= DW'(0);
            M_DO      <= 8'hFF;
            Z_DO      <= 8'hFF;
            M_DTACK_N <= 1'b1;
            Z_DTACK_N <= 1'b1;
            BUS_ERR   <= 1'b0;
        end else if (CE) begin
            state     <= state_nx;
            owner     <= owner_nx;
            last      <= last_nx;
            cnt       <= cnt_nx;
            IO_SEL    <= io_sel_nx;
            IO_RNW    <= io_rnw_nx;
            IO_A      <= io_a_nx;
            IO_DI     <= io_di_nx;
            M_DO      <= m_do_nx;
            Z_DO      <= z_do_nx;
            M_DTACK_N <= m_ack_nx;
            Z_DTACK_N <= z_ack_nx;
            BUS_ERR   <= bus_err_nx;
        end
    end
endmodule

// File: tb/tb_io_bus_arb.sv
// Bench for io_bus_arb: table of single-master transactions checked through a scoreboard,
// plus hand sequences for arbitration ties, timeout, abort, clock enable and reset.
module tb_io_bus_arb;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CE = 1'b1;
    logic       M_SEL = 1'b0, M_RNW = 1'b1;
    logic [3:0] M_A = 4'd0;
    logic [7:0] M_DI = 8'd0;
    logic [7:0] M_DO;
    logic       M_DTACK_N;
    logic       Z_SEL = 1'b0, Z_RNW = 1'b1;
    logic [3:0] Z_A = 4'd0;
    logic [7:0] Z_DI = 8'd0;
    logic [7:0] Z_DO;
    logic       Z_DTACK_N;
    logic       IO_SEL, IO_RNW;
    logic [3:0] IO_A;
    logic [7:0] IO_DI;
    logic [7:0] IO_DO = 8'd0;
    logic       IO_DTACK_N = 1'b1;
    logic       BUS_ERR;

    io_bus_arb dut (
        .CLK(CLK), .RESET(RESET), .CE(CE),
        .M_SEL(M_SEL), .M_RNW(M_RNW), .M_A(M_A), .M_DI(M_DI), .M_DO(M_DO), .M_DTACK_N(M_DTACK_N),
        .Z_SEL(Z_SEL), .Z_RNW(Z_RNW), .Z_A(Z_A), .Z_DI(Z_DI), .Z_DO(Z_DO), .Z_DTACK_N(Z_DTACK_N),
        .IO_SEL(IO_SEL), .IO_RNW(IO_RNW), .IO_A(IO_A), .IO_DI(IO_DI), .IO_DO(IO_DO),
        .IO_DTACK_N(IO_DTACK_N), .BUS_ERR(BUS_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         is_z;
        bit         rnw;
        logic [3:0] a;
        logic [7:0] di;
        logic [7:0] iod;
        int         dly;
        logic [7:0] exp_do;
    } vec_t;

    typedef struct {
        bit         is_z;
        logic [7:0] d;
    } sb_t;

    sb_t  sb[$];
    int   checks = 0;
    int   failures = 0;
    logic [7:0] m_last = 8'hFF, z_last = 8'hFF;

    // I/O block model: acknowledges io_delay clocks after it sees IO_SEL (never if negative)
    int         io_delay = -1;
    logic [7:0] io_data = 8'd0;
    int         rsp_cnt = 0;
    always @(posedge CLK) begin
        if (!IO_SEL) begin
            IO_DTACK_N <= 1'b1;
            rsp_cnt    <= 0;
        end else if (io_delay >= 0 && IO_DTACK_N) begin
            if (rsp_cnt == io_delay) begin
                IO_DTACK_N <= 1'b0;
                IO_DO      <= io_data;
            end else begin
                rsp_cnt <= rsp_cnt + 1;
            end
        end
    end

    // Clock-enable pattern: one enabled edge in four when ce_mode is set
    bit ce_mode = 0;
    int ce_ph = 0;
    always @(negedge CLK) begin
        if (ce_mode) begin
            ce_ph = ce_ph + 1;
            CE = (ce_ph % 4 == 3);
        end else begin
            CE = 1'b1;
        end
    end

    logic        ce_seen = 1'b1;
    logic [32:0] snap = '0, cur;
    bit          hold_bad = 0;
    always @(posedge CLK) ce_seen <= CE;
    always @(negedge CLK) begin
        cur = {M_DO, Z_DO, M_DTACK_N, Z_DTACK_N, IO_SEL, IO_RNW, IO_A, IO_DI, BUS_ERR};
        if (ce_mode && !ce_seen && !RESET && cur !== snap) hold_bad = 1;
        snap = cur;
    end

    bit         mon_on = 0, mon_z = 0, io_bad = 0, other_bad = 0, err_seen = 0;
    logic [3:0] exp_a;
    logic       exp_rnw;
    logic [7:0] exp_di;
    always @(negedge CLK) begin
        if (BUS_ERR === 1'b1) err_seen = 1;
        if (mon_on) begin
            if (IO_SEL && (IO_A !== exp_a || IO_RNW !== exp_rnw || IO_DI !== exp_di)) io_bad = 1;
            if ((mon_z ? M_DTACK_N : Z_DTACK_N) !== 1'b1) other_bad = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input bit is_z, input logic lvl, input int bound, output bit ok);
        int n = 0;
        while (((is_z ? Z_DTACK_N : M_DTACK_N) !== lvl) && n < bound) begin
            @(negedge CLK);
            n++;
        end
        ok = ((is_z ? Z_DTACK_N : M_DTACK_N) === lvl);
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        m_last = 8'hFF;
        z_last = 8'hFF;
    endtask

    task automatic do_txn(input vec_t v, input string name, input int settle);
        bit  ok;
        sb_t e;
        @(negedge CLK);
        io_data = v.iod;
        io_delay = v.dly;
        exp_a = v.a;
        exp_rnw = v.rnw;
        exp_di = v.di;
        io_bad = 0;
        other_bad = 0;
        mon_z = v.is_z;
        mon_on = 1;
        if (v.is_z) begin
            Z_SEL = 1'b1; Z_RNW = v.rnw; Z_A = v.a; Z_DI = v.di;
        end else begin
            M_SEL = 1'b1; M_RNW = v.rnw; M_A = v.a; M_DI = v.di;
        end
        e.is_z = v.is_z;
        e.d = v.exp_do;
        sb.push_back(e);
        wait_ack(v.is_z, 1'b0, 2000, ok);
        chk({name, " ack"}, 32'(ok), 32'd1);
        e = sb.pop_front();
        if (ok) begin
            chk({name, " do"}, e.is_z ? Z_DO : M_DO, e.d);
            chk({name, " other_do"}, e.is_z ? M_DO : Z_DO, e.is_z ? m_last : z_last);
            if (e.is_z) z_last = e.d; else m_last = e.d;
            repeat (2) @(negedge CLK);
            chk({name, " ack_held"}, e.is_z ? Z_DTACK_N : M_DTACK_N, 32'd0);
        end
        if (v.is_z) Z_SEL = 1'b0; else M_SEL = 1'b0;
        wait_ack(v.is_z, 1'b1, 2000, ok);
        chk({name, " ack_release"}, 32'(ok), 32'd1);
        chk({name, " io_sel_low"}, IO_SEL, 32'd0);
        mon_on = 0;
        chk({name, " io_stable"}, 32'(io_bad), 32'd0);
        chk({name, " other_ack"}, 32'(other_bad), 32'd0);
        repeat (settle) @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[7];
        bit   ok;
        int   n;

        vt[0] = '{0, 1, 4'd1,  8'h00, 8'h3F, 2, 8'h3F};
        vt[1] = '{1, 0, 4'd4,  8'h40, 8'h55, 1, 8'hFF};
        vt[2] = '{1, 1, 4'd2,  8'h00, 8'hA5, 0, 8'hA5};
        vt[3] = '{0, 0, 4'd7,  8'h12, 8'h00, 3, 8'h3F};
        vt[4] = '{1, 0, 4'd4,  8'h40, 8'h77, 2, 8'hA5};
        vt[5] = '{0, 1, 4'd15, 8'h00, 8'h00, 1, 8'h00};
        vt[6] = '{1, 1, 4'd0,  8'h00, 8'hC3, 4, 8'hC3};

        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst io_sel", IO_SEL, 32'd0);
        chk("rst io_rnw", IO_RNW, 32'd1);
        chk("rst io_a", IO_A, 32'd0);
        chk("rst io_di", IO_DI, 32'd0);
        chk("rst m_ack", M_DTACK_N, 32'd1);
        chk("rst z_ack", Z_DTACK_N, 32'd1);
        chk("rst m_do", M_DO, 32'hFF);
        chk("rst z_do", Z_DO, 32'hFF);
        chk("rst bus_err", BUS_ERR, 32'd0);
        RESET = 1'b0;

        for (int i = 0; i < 7; i++) do_txn(vt[i], $sformatf("vec%0d", i), 3);

        // Tie right after reset: 68K first, then the pending Z80 request
        reset_dut();
        @(negedge CLK);
        io_data = 8'h11; io_delay = 1;
        M_SEL = 1'b1; M_RNW = 1'b1; M_A = 4'd1;
        Z_SEL = 1'b1; Z_RNW = 1'b0; Z_A = 4'd4; Z_DI = 8'h40;
        for (int k = 0; k < 100; k++) begin
            if (M_DTACK_N === 1'b0 || Z_DTACK_N === 1'b0) break;
            @(negedge CLK);
        end
        chk("tie1 m_ack", M_DTACK_N, 32'd0);
        chk("tie1 z_ack", Z_DTACK_N, 32'd1);
        chk("tie1 m_do", M_DO, 32'h11);
        M_SEL = 1'b0;
        wait_ack(1'b1, 1'b0, 100, ok);
        chk("tie1 z_served", 32'(ok), 32'd1);
        chk("tie1 m_ack_off", M_DTACK_N, 32'd1);
        chk("tie1 z_do", Z_DO, 32'hFF);
        Z_SEL = 1'b0;
        wait_ack(1'b1, 1'b1, 100, ok);
        repeat (3) @(negedge CLK);
        m_last = 8'h11;

        do_txn('{0, 1, 4'd3, 8'h00, 8'h22, 0, 8'h22}, "m_single", 3);

        // 68K was granted last, so the next tie goes to the Z80 side
        @(negedge CLK);
        io_data = 8'h33; io_delay = 1;
        M_SEL = 1'b1; M_RNW = 1'b1; M_A = 4'd2;
        Z_SEL = 1'b1; Z_RNW = 1'b1; Z_A = 4'd5;
        for (int k = 0; k < 100; k++) begin
            if (M_DTACK_N === 1'b0 || Z_DTACK_N === 1'b0) break;
            @(negedge CLK);
        end
        chk("tie2 z_ack", Z_DTACK_N, 32'd0);
        chk("tie2 m_ack", M_DTACK_N, 32'd1);
        chk("tie2 z_do", Z_DO, 32'h33);
        Z_SEL = 1'b0;
        wait_ack(1'b0, 1'b0, 100, ok);
        chk("tie2 m_served", 32'(ok), 32'd1);
        chk("tie2 m_do", M_DO, 32'h33);
        M_SEL = 1'b0;
        wait_ack(1'b0, 1'b1, 100, ok);
        repeat (3) @(negedge CLK);
        m_last = 8'h33;
        z_last = 8'h33;

        // Timeout with the I/O block never answering
        @(negedge CLK);
        io_delay = -1;
        M_SEL = 1'b1; M_RNW = 1'b1; M_A = 4'd3;
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge CLK);
            if (M_DTACK_N === 1'b0) break;
            if (IO_SEL === 1'b1) n++;
        end
        chk("to ack", M_DTACK_N, 32'd0);
        chk("to grant_cycles", 32'(n), 32'd200);
        chk("to m_do", M_DO, 32'hFF);
        chk("to bus_err", BUS_ERR, 32'd1);
        chk("to io_sel", IO_SEL, 32'd0);
        @(negedge CLK);
        chk("to bus_err_pulse", BUS_ERR, 32'd0);
        chk("to ack_held", M_DTACK_N, 32'd0);
        M_SEL = 1'b0;
        wait_ack(1'b0, 1'b1, 100, ok);
        chk("to release", 32'(ok), 32'd1);
        repeat (3) @(negedge CLK);
        m_last = 8'hFF;

        // I/O acknowledge on the same cycle the timeout would fire
        err_seen = 0;
        do_txn('{0, 1, 4'd6, 8'h00, 8'h5A, 198, 8'h5A}, "to_race", 3);
        chk("to_race no_bus_err", 32'(err_seen), 32'd0);

        // Owner drops SEL in GRANT before any acknowledge
        @(negedge CLK);
        io_delay = -1;
        M_SEL = 1'b1; M_RNW = 1'b1; M_A = 4'd9;
        repeat (4) @(negedge CLK);
        chk("abort io_sel_high", IO_SEL, 32'd1);
        M_SEL = 1'b0;
        @(negedge CLK);
        chk("abort io_sel", IO_SEL, 32'd0);
        chk("abort m_ack", M_DTACK_N, 32'd1);
        chk("abort m_do", M_DO, 32'(m_last));
        repeat (4) @(negedge CLK);

        // Same read as the first vector with one enabled edge in four
        hold_bad = 0;
        ce_mode = 1;
        do_txn(vt[0], "ce_quarter", 16);
        chk("ce hold", 32'(hold_bad), 32'd0);
        ce_mode = 0;
        repeat (2) @(negedge CLK);

        // Reset while in HOLD
        @(negedge CLK);
        io_delay = 0; io_data = 8'h99;
        M_SEL = 1'b1; M_RNW = 1'b1; M_A = 4'd1;
        wait_ack(1'b0, 1'b0, 100, ok);
        chk("rh hold", 32'(ok), 32'd1);
        chk("rh m_do", M_DO, 32'h99);
        RESET = 1'b1;
        err_seen = 0;
        @(negedge CLK);
        chk("rh m_ack", M_DTACK_N, 32'd1);
        chk("rh z_ack", Z_DTACK_N, 32'd1);
        chk("rh io_sel", IO_SEL, 32'd0);
        chk("rh m_do_ff", M_DO, 32'hFF);
        chk("rh z_do_ff", Z_DO, 32'hFF);
        chk("rh bus_err", 32'(err_seen), 32'd0);
        M_SEL = 1'b0;
        RESET = 1'b0;
        m_last = 8'hFF;
        z_last = 8'hFF;
        repeat (2) @(negedge CLK);
        do_txn('{1, 1, 4'd8, 8'h00, 8'h6C, 1, 8'h6C}, "after_rst", 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
